mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 68 ++++++
 rtl/mult_div_unit_iter_core.sv | 64 ++++++
 rtl/mult_div_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the HI/LO multiply/divide unit:
//   - operation encodings (MULT, MULTU, DIV, DIVU)
//   - FSM state enumeration (IDLE, RUN, FIX)
//   - datapath width and iteration count
//   - small two's-complement helpers used for sign handling
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = 5;

    // Counter value on which the final radix-2 iteration is performed.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    // Magnitude of a 32-bit operand; only negated when the op is signed.
    // 32'h8000_0000 maps onto itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] mag32(input logic [WIDTH-1:0] v,
                                               input logic is_signed);
        logic [WIDTH-1:0] r;
        if (is_signed && v[WIDTH-1]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negate of a 32-bit value.
    function automatic logic [WIDTH-1:0] cneg32(input logic [WIDTH-1:0] v,
                                                input logic neg);
        logic [WIDTH-1:0] r;
        if (neg) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Conditional two's-complement negate of a 64-bit value.
    function automatic logic [2*WIDTH-1:0] cneg64(input logic [2*WIDTH-1:0] v,
                                                  input logic neg);
        logic [2*WIDTH-1:0] r;
        if (neg) begin
            r = ~v + 64'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_div_unit_iter_core.sv
// -----------------------------------------------------------------------------
// mdu_iter_core
// One radix-2 iteration step of the multiply/divide datapath (purely
// combinational; the working register lives in mult_div_unit).
//
// Working register layout (work_in / work_out, 64 bits):
//   multiply : {partial_product_hi[31:0], multiplier_remaining[31:0]}
//              step = add operand when LSB set, then shift right with carry
//   divide   : {partial_remainder[31:0], dividend_remaining/quotient[31:0]}
//              step = shift left, restoring trial subtract of operand,
//              quotient bit enters at LSB
//
// Ports:
//   is_div    in   1  select divide (1) or multiply (0) step
//   work_in   in  64  working register before the step
//   operand   in  32  multiplicand magnitude / divisor magnitude
//   work_out  out 64  working register after the step
// -----------------------------------------------------------------------------
module mdu_iter_core
    import mult_div_unit_pkg::*;
(
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   work_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   work_out
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] rem_sub_s;
    logic             ge_s;

    // Single shift-add or restoring subtract-shift step.
    always_comb begin
        sum_s     = 33'd0;
        rem_sh_s  = 33'd0;
        rem_sub_s = 32'd0;
        ge_s      = 1'b0;
        work_out  = work_in;

        // Partial remainder stays below the divisor, so after the shift it
        // needs 33 bits; the difference itself always fits back in 32.
        rem_sh_s  = {work_in[2*WIDTH-1:WIDTH], work_in[WIDTH-1]};
        ge_s      = (rem_sh_s >= {1'b0, operand});
        rem_sub_s = rem_sh_s[WIDTH-1:0] - operand;

        if (work_in[0]) begin
            sum_s = {1'b0, work_in[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        end else begin
            sum_s = {1'b0, work_in[2*WIDTH-1:WIDTH]};
        end

        if (is_div) begin
            if (ge_s) begin
                work_out = {rem_sub_s, work_in[WIDTH-2:0], 1'b1};
            end else begin
                work_out = {rem_sh_s[WIDTH-1:0], work_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            work_out = {sum_s, work_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative HI/LO multiply/divide unit with MTHI/MTLO write port and
// hazard-unit stall request. Operations run as IDLE -> RUN (32 radix-2
// iterations) -> FIX (sign correction, HI/LO write) -> IDLE.
//
// Optional build macro:
//   MDU_FAST_MULT_EN  MULT/MULTU computed in a single cycle (IDLE -> FIX);
//                     divides keep the iterative path.
//
// Ports:
//   clk            in   1  rising-edge clock
//   rst_n          in   1  asynchronous active-low reset
//   start_e        in   1  EX-stage mult/div issue
//   op_e           in   2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a_e        in  32  multiplicand / dividend
//   src_b_e        in  32  multiplier / divisor
//   flush_e        in   1  squashes a same-cycle start_e
//   abort          in   1  cancels the in-flight operation
//   we_hi, we_lo   in   1  MTHI / MTLO write strobes (honoured in IDLE)
//   wdata          in  32  MTHI / MTLO data
//   hilo_access_d  in   1  decode-stage instruction touches HI/LO or MDU
//   hi, lo         out 32  architectural HI / LO
//   busy           out  1  operation in flight (RUN or FIX)
//   stall_md       out  1  busy AND hilo_access_d
//   done           out  1  one-cycle pulse after the HI/LO update edge
// -----------------------------------------------------------------------------
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_e,
    input  logic [1:0]       op_e,
    input  logic [WIDTH-1:0] src_a_e,
    input  logic [WIDTH-1:0] src_b_e,
    input  logic             flush_e,
    input  logic             abort,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             hilo_access_d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_md,
    output logic             done
);

    md_state_e          state_r;
    md_state_e          state_nxt_s;
    logic               accept_s;
    logic               commit_s;
    logic               iter_s;

    logic [CNT_W-1:0]   cnt_r;
    md_op_e             op_r;
    logic [WIDTH-1:0]   operand_r;
    logic [2*WIDTH-1:0] work_r;
    logic               res_neg_r;
    logic               rem_neg_r;
    logic               div_zero_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               in_signed_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [2*WIDTH-1:0] step_s;
    logic [2*WIDTH-1:0] mul_res_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [WIDTH-1:0]   hi_fix_s;
    logic [WIDTH-1:0]   lo_fix_s;
`ifdef MDU_FAST_MULT_EN
    logic [2*WIDTH-1:0] fast_prod_s;
`endif

    // Operand magnitudes and signs for the issuing operation (MULT/DIV signed).
    always_comb begin
        in_signed_s = ~op_e[0];
        a_neg_s     = in_signed_s & src_a_e[WIDTH-1];
        b_neg_s     = in_signed_s & src_b_e[WIDTH-1];
        a_mag_s     = mag32(src_a_e, in_signed_s);
        b_mag_s     = mag32(src_b_e, in_signed_s);
    end

`ifdef MDU_FAST_MULT_EN
    // Full single-cycle unsigned product of the magnitudes.
    always_comb begin
        fast_prod_s = {32'd0, a_mag_s} * {32'd0, b_mag_s};
    end
`endif

    mdu_iter_core u_iter_core (
        .is_div   (op_r[1]),
        .work_in  (work_r),
        .operand  (operand_r),
        .work_out (step_s)
    );

    // Sign correction of the finished magnitude result; a zero divisor
    // forces an all-ones quotient while the remainder path returns the
    // dividend itself.
    always_comb begin
        mul_res_s = cneg64(work_r, res_neg_r);
        rem_s     = cneg32(work_r[2*WIDTH-1:WIDTH], rem_neg_r);
        if (div_zero_r) begin
            quo_s = 32'hFFFF_FFFF;
        end else begin
            quo_s = cneg32(work_r[WIDTH-1:0], res_neg_r);
        end
        if (op_r[1]) begin
            hi_fix_s = rem_s;
            lo_fix_s = quo_s;
        end else begin
            hi_fix_s = mul_res_s[2*WIDTH-1:WIDTH];
            lo_fix_s = mul_res_s[WIDTH-1:0];
        end
    end

    // FSM next-state and control decode; abort overrides RUN and FIX.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        commit_s    = 1'b0;
        iter_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_e && !flush_e) begin
                    accept_s = 1'b1;
`ifdef MDU_FAST_MULT_EN
                    if (op_e[1]) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = FIX;
                    end
`else
                    state_nxt_s = RUN;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    iter_s = 1'b1;
                    if (cnt_r == LAST_ITER) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
            end
            FIX: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    commit_s    = 1'b1;
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch on accept, then one iteration per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= 5'd0;
            op_r       <= OP_MULT;
            operand_r  <= 32'd0;
            work_r     <= 64'd0;
            res_neg_r  <= 1'b0;
            rem_neg_r  <= 1'b0;
            div_zero_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r      <= 5'd0;
            op_r       <= md_op_e'(op_e);
            res_neg_r  <= a_neg_s ^ b_neg_s;
            rem_neg_r  <= a_neg_s;
            div_zero_r <= op_e[1] & (src_b_e == 32'd0);
            if (op_e[1]) begin
                operand_r <= b_mag_s;
                work_r    <= {32'd0, a_mag_s};
            end else begin
                operand_r <= a_mag_s;
`ifdef MDU_FAST_MULT_EN
                work_r    <= fast_prod_s;
`else
                work_r    <= {32'd0, b_mag_s};
`endif
            end
        end else if (iter_s) begin
            work_r <= step_s;
            cnt_r  <= cnt_r + 5'd1;
        end
    end

    // Architectural HI/LO: result commit, or MTHI/MTLO when idle and not starting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
        end else if ((state_r == IDLE) && !accept_s) begin
            if (we_hi) begin
                hi_r <= wdata;
            end
            if (we_lo) begin
                lo_r <= wdata;
            end
        end
    end

    // Registered status: busy tracks RUN/FIX, done pulses after the commit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != IDLE);
            done_r <= commit_s;
        end
    end

    assign hi       = hi_r;
    assign lo       = lo_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign stall_md = busy_r & hilo_access_d;

endmodule
